// File: rtl/ws281x_tx.sv
// WS281X one-wire transmitter: serialises WIDTH-bit pixel words MSB first and inserts latch gaps.
// Optional build macro WS281X_TX_AUTOLATCH_EN inserts the latch gap after every NPIX-th word.
module ws281x_tx #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned T0H    = 16,
  parameter int unsigned T1H    = 32,
  parameter int unsigned TBIT   = 50,
  parameter int unsigned TLATCH = 2000,
  parameter int unsigned NPIX   = 8
) (
  input  logic             ClockEdge,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data,
  input  logic             Valid,
  output logic             Ready,
  input  logic             Latch,
  output logic             Dout,
  output logic             Busy,
  output logic [15:0]      PixelCount
);

  localparam int unsigned PW = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned LW = $clog2(TLATCH + 1);

  localparam logic [PW-1:0] PhaseLast = PW'(TBIT - 1);
  localparam logic [BW-1:0] BitLast   = BW'(WIDTH - 1);
  localparam logic [LW-1:0] LatchLast = LW'(TLATCH - 1);
  localparam logic [PW-1:0] T0hP      = PW'(T0H);
  localparam logic [PW-1:0] T1hP      = PW'(T1H);

  if (!(T0H >= 1 && T0H < T1H && T1H < TBIT && TLATCH >= 1 && NPIX >= 1)) begin : g_bad_params
    $error("ws281x_tx: illegal timing parameters");
  end

  typedef enum logic [1:0] {StIdle, StSend, StLatch} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [LW-1:0]    lcnt_q, lcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [15:0]      pcount_q, pcount_d;
  logic             pending_q, pending_d;
  logic             dout_q, dout_d;

  logic auto_req, latch_req, last_cycle, accept;
  logic [15:0] pcount_inc;

`ifdef WS281X_TX_AUTOLATCH_EN
  assign auto_req = ({16'd0, pcount_q} >= NPIX);
`else
  assign auto_req = 1'b0;
`endif

  // A Latch arriving in the final cycle of a pixel still blocks a gap-free accept.
  assign latch_req  = pending_q | Latch | auto_req;
  assign last_cycle = (state_q == StSend) && (phase_q == PhaseLast) && (bitcnt_q == BitLast);
  assign Ready      = !Reset && (((state_q == StIdle) && !pending_q && !Latch) ||
                                 (last_cycle && !latch_req));
  assign accept     = Valid && Ready;
  assign pcount_inc = (pcount_q == 16'hFFFF) ? pcount_q : pcount_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bitcnt_d  = bitcnt_q;
    lcnt_d    = lcnt_q;
    shreg_d   = shreg_q;
    pcount_d  = pcount_q;
    pending_d = pending_q;
    dout_d    = (state_q == StSend) &&
                (shreg_q[WIDTH-1] ? (phase_q < T1hP) : (phase_q < T0hP));

    case (state_q)
      StIdle: begin
        if (Latch) begin
          state_d = StLatch;
          lcnt_d  = '0;
        end else if (accept) begin
          state_d  = StSend;
          shreg_d  = Data;
          phase_d  = '0;
          bitcnt_d = '0;
          pcount_d = pcount_inc;
        end
      end
      StSend: begin
        if (Latch) pending_d = 1'b1;
        if (phase_q == PhaseLast) begin
          phase_d = '0;
          shreg_d = shreg_q << 1;
          if (bitcnt_q == BitLast) begin
            bitcnt_d = '0;
            if (accept) begin
              shreg_d  = Data;
              pcount_d = pcount_inc;
            end else if (latch_req) begin
              state_d = StLatch;
              lcnt_d  = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      StLatch: begin
        if (lcnt_q == LatchLast) begin
          state_d   = StIdle;
          pcount_d  = '0;
          pending_d = 1'b0;
        end else begin
          lcnt_d = lcnt_q + LW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ClockEdge) begin
    if (Reset) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      bitcnt_q  <= '0;
      lcnt_q    <= '0;
      shreg_q   <= '0;
      pcount_q  <= '0;
      pending_q <= 1'b0;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bitcnt_q  <= bitcnt_d;
      lcnt_q    <= lcnt_d;
      shreg_q   <= shreg_d;
      pcount_q  <= pcount_d;
      pending_q <= pending_d;
      dout_q    <= dout_d;
    end
  end

  assign Dout       = dout_q;
  assign Busy       = (state_q != StIdle);
  assign PixelCount = pcount_q;

endmodule
